video_req_scheduler: RTL and testbench
======================================

VIDEO_REQ_SCHEDULER -- requirements
Module: video_req_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the per-frame collision counter.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port i_vsync, i_hsync  input  1 each  active-high raw sync from timing generator.
REQ-005 SHALL have port i_hit  input  2  per-layer opaque-pixel flag for the current pixel.
REQ-006 SHALL have port i_cfg_valid  input  1  config write request.
REQ-007 SHALL have port i_cfg_en  input  2  per-layer enable to load.
REQ-008 SHALL have port i_cfg_swap  input  1  1 = layer 0 beats layer 1.
REQ-009 SHALL have port o_cfg_ready  output  1  config can be accepted.
REQ-010 SHALL have port o_req  output  2  one-hot (or zero) layer grant for the downstream video arbiter.
REQ-011 SHALL have port o_vsync, o_hsync  output  1 each  syncs delayed to align with o_req.
REQ-012 SHALL have port o_collide  output  1  previous frame had at least one collision.
REQ-013 SHALL have port o_collide_cnt  output  CNT_W  previous-frame collision count.

Function
REQ-014 SHALL run FSM WAIT, VBLANK, ACTIVE; WAIT->VBLANK on i_vsync rising edge; VBLANK->ACTIVE on i_vsync falling edge; ACTIVE->VBLANK on i_vsync rising edge.
REQ-015 SHALL detect edges against a registered copy of i_vsync; frame boundary = rising edge of i_vsync.
REQ-016 SHALL register o_req, o_hsync, o_vsync with exactly 1 cycle latency from i_hit/i_hsync/i_vsync.
REQ-017 SHALL drive o_req = 0 in WAIT, in VBLANK, and whenever i_hsync = 1.
REQ-018 In ACTIVE with i_hsync = 0, candidates = i_hit AND active_en; one candidate -> that bit; both -> bit 1 if active_swap = 0, else bit 0; none -> 0.
REQ-019 o_req SHALL never have both bits set.
REQ-020 Config handshake: transfer when i_cfg_valid and o_cfg_ready; i_cfg_en/i_cfg_swap latched into shadow, pending set, o_cfg_ready low from next cycle.
REQ-021 At frame boundary with pending set, active_en/active_swap SHALL load from shadow, pending clears, o_cfg_ready high next cycle.
REQ-022 Config accepted mid-frame SHALL NOT affect o_req before the next boundary.
REQ-023 Transfer on a boundary cycle (pending clear) SHALL be held and applied at the following boundary.
REQ-024 Collision = ACTIVE, i_hsync = 0, both i_hit bits set, both active_en bits set; counter increments by 1, saturates at 2^CNT_W-1.
REQ-025 At frame boundary: o_collide_cnt <= counter, o_collide <= (counter != 0), counter <= 0.

Reset
REQ-026 SHALL on i_rst_n low, immediately: state WAIT, o_req 0, o_vsync 0, o_hsync 0, o_cfg_ready 1, pending 0, active_en 2'b11, active_swap 0, shadow 0, counter 0, o_collide 0, o_collide_cnt 0, vsync history 0.
REQ-027 Reset mid-frame SHALL discard pending config and count; first boundary after release moves WAIT->VBLANK only.

Configuration
REQ-028 Macro VIDEO_SCHED_COLLIDE_EN defined: REQ-024/025 implemented.
REQ-029 Macro undefined: no counter logic; o_collide tied 0, o_collide_cnt tied 0; ports unchanged; all else identical.

Verification
REQ-030 Reset then i_hit=2'b11 before any vsync -> o_req stays 2'b00 (WAIT).
REQ-031 After one vsync pulse, ACTIVE, i_hit=2'b11, defaults -> o_req=2'b10 one cycle later; i_hsync=1 -> o_req=2'b00.
REQ-032 Mid-frame cfg en=2'b01 swap=1 -> o_cfg_ready low, o_req still 2'b10 for i_hit=2'b11; after next vsync rise -> o_req=2'b01, o_cfg_ready high.
REQ-033 With VIDEO_SCHED_COLLIDE_EN, 5 ACTIVE cycles i_hit=2'b11 then vsync rise -> o_collide_cnt=5, o_collide=1; next frame no hits -> 0/0.
REQ-034 CNT_W=4, 20 collision cycles -> o_collide_cnt=15 at boundary.
REQ-035 i_rst_n low mid-frame with pending config -> all outputs reset values same cycle, o_cfg_ready=1, old config never applied.

Source files
------------

// File: rtl/video_req_scheduler.sv
// Video layer request scheduler.
// Tracks frame phase from raw vsync and grants one of two layers per pixel
// from the opaque-pixel flags. Layer config is double-buffered and takes
// effect at the next frame boundary. Optional per-frame collision counting
// is compiled in when VIDEO_SCHED_COLLIDE_EN is defined.
module video_req_scheduler #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_vsync,
   input  logic             i_hsync,
   input  logic [1:0]       i_hit,
   input  logic             i_cfg_valid,
   input  logic [1:0]       i_cfg_en,
   input  logic             i_cfg_swap,
   output logic             o_cfg_ready,
   output logic [1:0]       o_req,
   output logic             o_vsync,
   output logic             o_hsync,
   output logic             o_collide,
   output logic [CNT_W-1:0] o_collide_cnt
);

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_VBLANK = 2'd1,
      ST_ACTIVE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        vsync_q;
   logic        hsync_q;
   logic [1:0]  req_q, req_d;
   logic        cfg_ready_q, cfg_ready_d;
   logic [1:0]  shadow_en_q, shadow_en_d;
   logic        shadow_swap_q, shadow_swap_d;
   logic [1:0]  active_en_q, active_en_d;
   logic        active_swap_q, active_swap_d;

   logic        vs_rise_c;
   logic        vs_fall_c;
   logic        pixel_live_c;
   logic [1:0]  cand_c;

   // Edges are taken against the registered vsync, which also serves as o_vsync.
   assign vs_rise_c    = i_vsync & ~vsync_q;
   assign vs_fall_c    = ~i_vsync & vsync_q;
   assign pixel_live_c = (state_q == ST_ACTIVE) && !i_hsync;
   assign cand_c       = i_hit & active_en_q;

   // State and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= ST_WAIT;
         vsync_q       <= 1'b0;
         hsync_q       <= 1'b0;
         req_q         <= 2'b00;
         cfg_ready_q   <= 1'b1;
         shadow_en_q   <= 2'b00;
         shadow_swap_q <= 1'b0;
         active_en_q   <= 2'b11;
         active_swap_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         vsync_q       <= i_vsync;
         hsync_q       <= i_hsync;
         req_q         <= req_d;
         cfg_ready_q   <= cfg_ready_d;
         shadow_en_q   <= shadow_en_d;
         shadow_swap_q <= shadow_swap_d;
         active_en_q   <= active_en_d;
         active_swap_q <= active_swap_d;
      end
   end

   // Frame FSM, layer grant and config double-buffer next-state logic.
   always_comb begin
      state_d       = state_q;
      req_d         = 2'b00;
      cfg_ready_d   = cfg_ready_q;
      shadow_en_d   = shadow_en_q;
      shadow_swap_d = shadow_swap_q;
      active_en_d   = active_en_q;
      active_swap_d = active_swap_q;

      unique case (state_q)
         ST_WAIT:   if (vs_rise_c) state_d = ST_VBLANK;
         ST_VBLANK: if (vs_fall_c) state_d = ST_ACTIVE;
         ST_ACTIVE: if (vs_rise_c) state_d = ST_VBLANK;
         default:   state_d = ST_WAIT;
      endcase

      // Two opaque candidates: layer 1 wins unless swap gives priority to layer 0.
      if (pixel_live_c) begin
         if (cand_c == 2'b11) begin
            req_d = active_swap_q ? 2'b01 : 2'b10;
         end else begin
            req_d = cand_c;
         end
      end

      // Pending config (ready low) is promoted at the frame boundary.
      if (vs_rise_c && !cfg_ready_q) begin
         active_en_d   = shadow_en_q;
         active_swap_d = shadow_swap_q;
         cfg_ready_d   = 1'b1;
      end

      // A transfer can only occur while nothing is pending, so it never
      // collides with the promotion above; a boundary-cycle transfer waits
      // for the following boundary.
      if (i_cfg_valid && cfg_ready_q) begin
         shadow_en_d   = i_cfg_en;
         shadow_swap_d = i_cfg_swap;
         cfg_ready_d   = 1'b0;
      end
   end

   assign o_req       = req_q;
   assign o_vsync     = vsync_q;
   assign o_hsync     = hsync_q;
   assign o_cfg_ready = cfg_ready_q;

`ifdef VIDEO_SCHED_COLLIDE_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             collide_q, collide_d;
   logic [CNT_W-1:0] collide_cnt_q, collide_cnt_d;
   logic             hit_both_c;

   assign hit_both_c = pixel_live_c && (i_hit == 2'b11) && (active_en_q == 2'b11);

   // Collision counter and previous-frame result registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q         <= '0;
         collide_q     <= 1'b0;
         collide_cnt_q <= '0;
      end else begin
         cnt_q         <= cnt_d;
         collide_q     <= collide_d;
         collide_cnt_q <= collide_cnt_d;
      end
   end

   // Boundary publishes and clears the count; otherwise saturating increment.
   always_comb begin
      cnt_d         = cnt_q;
      collide_d     = collide_q;
      collide_cnt_d = collide_cnt_q;
      if (vs_rise_c) begin
         collide_cnt_d = cnt_q;
         collide_d     = (cnt_q != '0);
         cnt_d         = '0;
      end else if (hit_both_c && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign o_collide     = collide_q;
   assign o_collide_cnt = collide_cnt_q;
`else
   assign o_collide     = 1'b0;
   assign o_collide_cnt = '0;
`endif

endmodule

// File: tb/tb_video_req_scheduler.sv
// Directed bench for video_req_scheduler with a frame-level reference model.
// Instantiates the default-width block and a 4-bit-counter copy side by side.
module tb_video_req_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        vsync = 1'b0;
   logic        hsync = 1'b0;
   logic [1:0]  hit = 2'b00;
   logic        cfg_valid = 1'b0;
   logic [1:0]  cfg_en = 2'b00;
   logic        cfg_swap = 1'b0;

   logic        ready_a, ready_b;
   logic [1:0]  req_a, req_b;
   logic        vs_a, vs_b, hs_a, hs_b;
   logic        col_a, col_b;
   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;

   int tests = 0;
   int fails = 0;

`ifdef VIDEO_SCHED_COLLIDE_EN
   localparam bit COLL = 1'b1;
`else
   localparam bit COLL = 1'b0;
`endif

   video_req_scheduler #(.CNT_W(16)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_hsync(hsync), .i_hit(hit),
      .i_cfg_valid(cfg_valid), .i_cfg_en(cfg_en), .i_cfg_swap(cfg_swap),
      .o_cfg_ready(ready_a), .o_req(req_a), .o_vsync(vs_a), .o_hsync(hs_a),
      .o_collide(col_a), .o_collide_cnt(cnt_a)
   );

   video_req_scheduler #(.CNT_W(4)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_hsync(hsync), .i_hit(hit),
      .i_cfg_valid(cfg_valid), .i_cfg_en(cfg_en), .i_cfg_swap(cfg_swap),
      .o_cfg_ready(ready_b), .o_req(req_b), .o_vsync(vs_b), .o_hsync(hs_b),
      .o_collide(col_b), .o_collide_cnt(cnt_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame phase, per-pixel winner, double-buffered config, counts.
   int          m_phase = 0;          // 0 waiting for first frame, 1 blanking, 2 active
   bit          m_vs_prev = 0;
   bit [1:0]    m_en = 2'b11;
   bit          m_swap = 0;
   bit [1:0]    m_sh_en = 2'b00;
   bit          m_sh_swap = 0;
   bit          m_pending = 0;
   int          m_cnt_a = 0, m_cnt_b = 0;
   bit [1:0]    e_req = 0;
   bit          e_vs = 0, e_hs = 0;
   int          e_cnt_a = 0, e_cnt_b = 0;

   function automatic bit [1:0] winner(input bit [1:0] h, input bit [1:0] en, input bit sw);
      bit [1:0] c;
      c = h & en;
      if (c == 2'b11) return sw ? 2'b01 : 2'b10;
      return c;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_vs_prev = 0; m_en = 2'b11; m_swap = 0;
         m_sh_en = 0; m_sh_swap = 0; m_pending = 0;
         m_cnt_a = 0; m_cnt_b = 0; e_req = 0; e_vs = 0; e_hs = 0;
         e_cnt_a = 0; e_cnt_b = 0;
      end else begin
         bit rise, fall, live, was_pending;
         rise = vsync && !m_vs_prev;
         fall = !vsync && m_vs_prev;
         live = (m_phase == 2) && !hsync;
         e_req = live ? winner(hit, m_en, m_swap) : 2'b00;
         e_vs = vsync;
         e_hs = hsync;
         if (rise) begin
            e_cnt_a = m_cnt_a; e_cnt_b = m_cnt_b;
            m_cnt_a = 0; m_cnt_b = 0;
         end else if (live && hit == 2'b11 && m_en == 2'b11) begin
            if (m_cnt_a < 65535) m_cnt_a++;
            if (m_cnt_b < 15) m_cnt_b++;
         end
         was_pending = m_pending;
         if (rise && was_pending) begin
            m_en = m_sh_en; m_swap = m_sh_swap; m_pending = 0;
         end
         if (cfg_valid && !was_pending) begin
            m_sh_en = cfg_en; m_sh_swap = cfg_swap; m_pending = 1;
         end
         if (rise) m_phase = 1;
         else if (fall && m_phase == 1) m_phase = 2;
         m_vs_prev = vsync;
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      check("req_a", 32'(req_a), 32'(e_req));
      check("req_b", 32'(req_b), 32'(e_req));
      check("vsync", 32'(vs_a), 32'(e_vs));
      check("hsync", 32'(hs_a), 32'(e_hs));
      check("ready_a", 32'(ready_a), 32'(!m_pending));
      check("ready_b", 32'(ready_b), 32'(!m_pending));
      check("col_a", 32'(col_a), 32'(COLL && e_cnt_a != 0));
      check("cnt_a", 32'(cnt_a), COLL ? 32'(e_cnt_a) : 32'd0);
      check("col_b", 32'(col_b), 32'(COLL && e_cnt_b != 0));
      check("cnt_b", 32'(cnt_b), COLL ? 32'(e_cnt_b) : 32'd0);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      tick(3);
      check("rst_req", 32'(req_a), 32'd0);
      check("rst_ready", 32'(ready_a), 32'd1);
      check("rst_cnt", 32'(cnt_a), 32'd0);
      rst_n = 1'b1;

      // Hits before any vsync: still waiting for a frame.
      hit = 2'b11;
      tick(3);
      check("wait_req", 32'(req_a), 32'd0);

      // One vsync pulse into the active region.
      hit = 2'b00; vsync = 1'b1;
      tick(1);
      check("vs_out", 32'(vs_a), 32'd1);
      vsync = 1'b0;
      tick(1);
      hit = 2'b11;
      tick(1);
      check("default_win", 32'(req_a), 32'h2);
      hsync = 1'b1;
      tick(1);
      check("hsync_blank", 32'(req_a), 32'd0);
      check("hsync_out", 32'(hs_a), 32'd1);
      hsync = 1'b0; hit = 2'b00;

      // Mid-frame config must not take effect yet.
      cfg_valid = 1'b1; cfg_en = 2'b01; cfg_swap = 1'b1;
      tick(1);
      cfg_valid = 1'b0;
      check("cfg_busy", 32'(ready_a), 32'd0);
      hit = 2'b11;
      tick(4);
      check("old_cfg", 32'(req_a), 32'h2);
      hit = 2'b00; vsync = 1'b1;
      tick(1);
      check("cfg_free", 32'(ready_a), 32'd1);
      check("cnt5_a", 32'(cnt_a), COLL ? 32'd5 : 32'd0);
      check("col5_a", 32'(col_a), 32'(COLL));
      vsync = 1'b0;
      tick(1);
      hit = 2'b11;
      tick(1);
      check("new_cfg", 32'(req_a), 32'h1);
      hit = 2'b10;
      tick(1);
      check("l1_off", 32'(req_a), 32'd0);
      hit = 2'b01;
      tick(1);
      check("l0_only", 32'(req_a), 32'h1);

      // Boundary with no collisions; config offered on the boundary cycle itself.
      hit = 2'b00; vsync = 1'b1;
      cfg_valid = 1'b1; cfg_en = 2'b11; cfg_swap = 1'b0;
      tick(1);
      cfg_valid = 1'b0;
      check("cnt0_a", 32'(cnt_a), 32'd0);
      check("col0_a", 32'(col_a), 32'd0);
      check("held_busy", 32'(ready_a), 32'd0);
      vsync = 1'b0;
      tick(1);
      hit = 2'b11;
      tick(1);
      check("held_old", 32'(req_a), 32'h1);
      hit = 2'b00; vsync = 1'b1;
      tick(1);
      check("held_free", 32'(ready_a), 32'd1);
      vsync = 1'b0;
      tick(1);

      // Twenty collisions saturate the 4-bit counter.
      hit = 2'b11;
      tick(20);
      check("restored", 32'(req_a), 32'h2);
      hit = 2'b00; vsync = 1'b1;
      tick(1);
      check("sat_b", 32'(cnt_b), COLL ? 32'd15 : 32'd0);
      check("cnt20_a", 32'(cnt_a), COLL ? 32'd20 : 32'd0);
      vsync = 1'b0;
      tick(1);

      // Reset mid-frame with a pending config.
      cfg_valid = 1'b1; cfg_en = 2'b00; cfg_swap = 1'b1;
      tick(1);
      cfg_valid = 1'b0;
      hit = 2'b11;
      tick(2);
      rst_n = 1'b0;
      #1;
      check("mrst_req", 32'(req_a), 32'd0);
      check("mrst_ready", 32'(ready_a), 32'd1);
      check("mrst_col", 32'(col_a), 32'd0);
      check("mrst_cnt", 32'(cnt_b), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      check("mrst_wait", 32'(req_a), 32'd0);
      hit = 2'b00; vsync = 1'b1;
      tick(1);
      vsync = 1'b0;
      tick(1);
      hit = 2'b11;
      tick(1);
      check("mrst_default", 32'(req_a), 32'h2);
      check("mrst_ready2", 32'(ready_a), 32'd1);
      hit = 2'b00;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
